// File: rtl/sprite_line_scheduler.sv
// Per-line sprite scheduler: scans the attribute table for sprites that cover the next beam row,
// fetches 16 pixels per hit from the sprite ROM and writes the opaque on-screen pixels to the line RAM.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 8
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic        i_line_start,
  input  logic [9:0]  i_next_row,
  input  logic        i_attr_we,
  input  logic [4:0]  i_attr_addr,
  input  logic [11:0] i_attr_wdata,
  output logic [5:0]  o_rom_sprite,
  output logic [2:0]  o_rom_row,
  output logic [2:0]  o_rom_col,
  input  logic [1:0]  i_rom_pixel,
  output logic        o_lr_write,
  output logic [9:0]  o_lr_addr,
  output logic [1:0]  o_lr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;

  logic [9:0] slot_x   [NUM_SPRITES];
  logic [9:0] slot_y   [NUM_SPRITES];
  logic       slot_en  [NUM_SPRITES];
  logic [5:0] slot_num [NUM_SPRITES];

  // One register set per slot; field 3 is reserved and never stored.
  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
      logic [9:0] x_reg;
      logic [9:0] y_reg;
      logic       en_reg;
      logic [5:0] num_reg;
      logic       sel;

      assign sel = i_attr_we && (i_attr_addr[4:2] == 3'(gi));

      always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
          x_reg   <= '0;
          y_reg   <= '0;
          en_reg  <= 1'b0;
          num_reg <= '0;
        end else if (sel) begin
          case (i_attr_addr[1:0])
            2'd0: x_reg <= i_attr_wdata[9:0];
            2'd1: y_reg <= i_attr_wdata[9:0];
            2'd2: begin
              en_reg  <= i_attr_wdata[6];
              num_reg <= i_attr_wdata[5:0];
            end
            default: ;
          endcase
        end
      end

      assign slot_x[gi]   = x_reg;
      assign slot_y[gi]   = y_reg;
      assign slot_en[gi]  = en_reg;
      assign slot_num[gi] = num_reg;
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [9:0] row_reg, row_next;
  logic [9:0] wx_reg, wx_next;
  logic [5:0] wnum_reg, wnum_next;
  logic [2:0] wrow_reg, wrow_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [9:0] pcol_reg, pcol_next;
  logic       pvalid_reg, pvalid_next;
  logic       overrun_reg, overrun_next;

  logic [9:0] scan_dy;
  logic       scan_hit;
  logic [9:0] fetch_col;

  // Slot fields are read live during SCAN so writes to unscanned slots land in this build.
  assign scan_dy   = row_reg - slot_y[idx_reg];
  assign scan_hit  = slot_en[idx_reg] && (scan_dy[9:4] == 6'd0);
  assign fetch_col = wx_reg + {6'd0, cnt_reg};

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    row_next     = row_reg;
    wx_next      = wx_reg;
    wnum_next    = wnum_reg;
    wrow_next    = wrow_reg;
    cnt_next     = cnt_reg;
    pcol_next    = fetch_col;
    pvalid_next  = (state_reg == FETCH);
    overrun_next = overrun_reg | (i_line_start && (state_reg != IDLE));

    case (state_reg)
      IDLE: begin
        if (i_line_start) begin
          row_next   = i_next_row;
          idx_next   = 3'(NUM_SPRITES - 1);
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (scan_hit) begin
          wx_next    = slot_x[idx_reg];
          wnum_next  = slot_num[idx_reg];
          wrow_next  = scan_dy[3:1];
          cnt_next   = 4'd0;
          state_next = FETCH;
        end else if (idx_reg == 3'd0) begin
          state_next = DRAIN;
        end else begin
          idx_next = idx_reg - 3'd1;
        end
      end
      FETCH: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd15) begin
          if (idx_reg == 3'd0) begin
            state_next = DRAIN;
          end else begin
            idx_next   = idx_reg - 3'd1;
            state_next = SCAN;
          end
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      row_reg     <= '0;
      wx_reg      <= '0;
      wnum_reg    <= '0;
      wrow_reg    <= '0;
      cnt_reg     <= '0;
      pcol_reg    <= '0;
      pvalid_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      row_reg     <= row_next;
      wx_reg      <= wx_next;
      wnum_reg    <= wnum_next;
      wrow_reg    <= wrow_next;
      cnt_reg     <= cnt_next;
      pcol_reg    <= pcol_next;
      pvalid_reg  <= pvalid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign o_rom_sprite = (state_reg == FETCH) ? wnum_reg     : 6'd0;
  assign o_rom_row    = (state_reg == FETCH) ? wrow_reg     : 3'd0;
  assign o_rom_col    = (state_reg == FETCH) ? cnt_reg[3:1] : 3'd0;

  // Write stage pairs the pipelined column with the ROM data returned this cycle.
  assign o_lr_write = pvalid_reg && (i_rom_pixel != 2'd0) && (pcol_reg < 10'd640);
  assign o_lr_addr  = pcol_reg;
  assign o_lr_data  = i_rom_pixel;

  assign o_busy    = (state_reg != IDLE);
  assign o_done    = (state_reg == DRAIN);
  assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: a per-build cycle model derived from the scan/fetch
// rules is compared against the DUT every cycle, plus hand-computed line RAM and length values.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        line_start;
  logic [9:0]  next_row;
  logic        attr_we;
  logic [4:0]  attr_addr;
  logic [11:0] attr_wdata;
  logic [5:0]  rom_sprite;
  logic [2:0]  rom_row;
  logic [2:0]  rom_col;
  logic [1:0]  rom_pixel;
  logic        lr_write;
  logic [9:0]  lr_addr;
  logic [1:0]  lr_data;
  logic        busy, done, overrun;

  always #5 clk = ~clk;

  sprite_line_scheduler #(.NUM_SPRITES(8)) dut (
    .i_Clk(clk), .i_Reset_n(reset_n), .i_line_start(line_start), .i_next_row(next_row),
    .i_attr_we(attr_we), .i_attr_addr(attr_addr), .i_attr_wdata(attr_wdata),
    .o_rom_sprite(rom_sprite), .o_rom_row(rom_row), .o_rom_col(rom_col),
    .i_rom_pixel(rom_pixel), .o_lr_write(lr_write), .o_lr_addr(lr_addr), .o_lr_data(lr_data),
    .o_busy(busy), .o_done(done), .o_overrun(overrun)
  );

  // Sprite ROM contents: pixel value is (sprite + row + col) mod 4, zero is transparent.
  function automatic logic [1:0] romf(input int sp, input int r, input int c);
    return 2'((sp + r + c) % 4);
  endfunction

  always @(posedge clk) rom_pixel <= romf(int'(rom_sprite), int'(rom_row), int'(rom_col));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bench copy of the attribute table.
  int sx[8], sy[8], snum[8];
  int sen[8];

  // Expected per-cycle trace of one build, indexed by cycles after the start pulse.
  int e_busy[300], e_done[300], e_wr[300], e_addr[300], e_data[300];
  int e_rs[300], e_rr[300], e_rc[300];
  int e_len, e_nwr;

  task automatic build_model(input int row);
    int k, dy, col, px;
    for (int i = 0; i < 300; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_wr[i] = 0; e_addr[i] = 0; e_data[i] = 0;
      e_rs[i] = 0; e_rr[i] = 0; e_rc[i] = 0;
    end
    e_nwr = 0;
    k = 1;
    for (int s = 7; s >= 0; s--) begin
      dy = (row - sy[s]) & 1023;
      k++;
      if (sen[s] != 0 && dy < 16) begin
        for (int c = 0; c < 16; c++) begin
          e_rs[k + c] = snum[s];
          e_rr[k + c] = dy / 2;
          e_rc[k + c] = c / 2;
          col = (sx[s] + c) & 1023;
          px  = int'(romf(snum[s], dy / 2, c / 2));
          if (px != 0 && col < 640) begin
            e_wr[k + c + 1]   = 1;
            e_addr[k + c + 1] = col;
            e_data[k + c + 1] = px;
            e_nwr++;
          end
        end
        k += 16;
      end
    end
    e_len = k;
    e_done[k] = 1;
    for (int i = 1; i <= k; i++) e_busy[i] = 1;
  endtask

  int start_cyc = 0;
  bit chk_on = 0;
  int nwr = 0;
  int lr_cap[1024];
  int kk;

  always @(negedge clk) begin
    if (chk_on) begin
      kk = cyc - start_cyc;
      if (kk >= 1 && kk <= e_len + 1) begin
        chk("busy", int'(busy), e_busy[kk]);
        chk("done", int'(done), e_done[kk]);
        chk("lr_write", int'(lr_write), e_wr[kk]);
        if (e_wr[kk] != 0 && lr_write) begin
          chk("lr_addr", int'(lr_addr), e_addr[kk]);
          chk("lr_data", int'(lr_data), e_data[kk]);
        end
        chk("rom_sprite", int'(rom_sprite), e_rs[kk]);
        chk("rom_row", int'(rom_row), e_rr[kk]);
        chk("rom_col", int'(rom_col), e_rc[kk]);
      end
      if (lr_write) begin
        chk("lr_addr_range", int'(lr_addr < 10'd640), 1);
        nwr++;
        lr_cap[lr_addr] = int'(lr_data);
      end
    end
  end

  task automatic wr(input int slot, input int field, input int data, input bit upd);
    attr_we    = 1'b1;
    attr_addr  = 5'(slot * 4 + field);
    attr_wdata = 12'(data);
    @(negedge clk);
    attr_we = 1'b0;
    if (upd) begin
      case (field)
        0: sx[slot] = data & 1023;
        1: sy[slot] = data & 1023;
        2: begin sen[slot] = (data >> 6) & 1; snum[slot] = data & 63; end
        default: ;
      endcase
    end
  endtask

  task automatic set_slot(input int slot, input int x, input int y, input int en, input int num);
    wr(slot, 0, x, 1);
    wr(slot, 1, y, 1);
    wr(slot, 2, (en << 6) | num, 1);
  endtask

  // Returns at the negedge of the first build cycle.
  task automatic start_build(input int row, input bit do_model);
    if (do_model) build_model(row);
    for (int i = 0; i < 1024; i++) lr_cap[i] = 0;
    line_start = 1'b1;
    next_row   = 10'(row);
    start_cyc  = cyc;
    nwr        = 0;
    chk_on     = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic finish_build(input string name, input int row);
    while (cyc - start_cyc < e_len + 2) @(negedge clk);
    chk_on = 1'b0;
    chk({name, "_writes"}, nwr, e_nwr);
    $display("build %s row=%0d len=%0d writes=%0d expected_writes=%0d", name, row, e_len, nwr, e_nwr);
  endtask

  int quiet;

  initial begin
    reset_n = 1'b0; line_start = 1'b0; next_row = '0;
    attr_we = 1'b0; attr_addr = '0; attr_wdata = '0;
    for (int i = 0; i < 8; i++) begin sx[i] = 0; sy[i] = 0; sen[i] = 0; snum[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_lr_write", int'(lr_write), 0);
    chk("rst_rom_sprite", int'(rom_sprite), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty table.
    start_build(5, 1);
    chk("empty_len", e_len, 9);
    finish_build("empty", 5);

    // Single sprite, ROM row 3.
    set_slot(3, 100, 10, 1, 1);
    start_build(17, 1);
    chk("single_len", e_len, 25);
    chk("single_model_writes", e_nwr, 12);
    finish_build("single", 17);
    chk("single_col100", lr_cap[100], 0);
    chk("single_col102", lr_cap[102], 1);
    chk("single_col104", lr_cap[104], 2);
    wr(3, 2, 0, 1);

    // Overlapping sprites: slot 0 drawn last.
    set_slot(1, 200, 0, 1, 2);
    set_slot(0, 200, 0, 1, 3);
    start_build(0, 1);
    chk("prio_len", e_len, 41);
    finish_build("priority", 0);
    chk("prio_col200", lr_cap[200], 3);
    chk("prio_col202", lr_cap[202], 3);
    chk("prio_col204", lr_cap[204], 1);
    wr(0, 2, 0, 1);
    wr(1, 2, 0, 1);

    // Right edge clip and wrap past 1023.
    set_slot(2, 630, 50, 1, 0);
    set_slot(1, 1020, 50, 1, 0);
    start_build(50, 1);
    chk("clip_len", e_len, 41);
    chk("clip_model_writes", e_nwr, 16);
    finish_build("clip_wrap", 50);
    chk("clip_col637", lr_cap[637], 3);
    chk("clip_col0", lr_cap[0], 2);
    wr(1, 2, 0, 1);
    wr(2, 2, 0, 1);

    // Overrun, and row 1023 against Y=0 is a miss.
    set_slot(4, 0, 0, 1, 5);
    chk("overrun_before", int'(overrun), 0);
    start_build(1023, 1);
    chk("row1023_len", e_len, 9);
    repeat (2) @(negedge clk);
    line_start = 1'b1;
    next_row   = 10'd0;
    @(negedge clk);
    line_start = 1'b0;
    finish_build("overrun", 1023);
    chk("overrun_after", int'(overrun), 1);
    wr(4, 2, 0, 1);

    // Writes during a build: slot 5 in FETCH is unaffected, slot 0 not yet scanned takes effect.
    set_slot(5, 300, 40, 1, 4);
    sx[0] = 10; sy[0] = 45; sen[0] = 1; snum[0] = 2;
    start_build(45, 1);
    chk("midwr_len", e_len, 41);
    repeat (3) @(negedge clk);
    wr(5, 0, 500, 0);
    wr(0, 0, 10, 0);
    wr(0, 1, 45, 0);
    wr(0, 2, 64 + 2, 0);
    finish_build("mid_write", 45);
    chk("midwr_col300", lr_cap[300], 2);
    chk("midwr_col10", lr_cap[10], 2);
    sx[5] = 500;

    // Reset during FETCH aborts the build and clears the table.
    start_build(45, 1);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    reset_n = 1'b0;
    chk_on  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_lr_write", int'(lr_write), 0);
    chk("abort_rom_sprite", int'(rom_sprite), 0);
    chk("abort_overrun", int'(overrun), 0);
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (lr_write || done || busy) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    for (int i = 0; i < 8; i++) begin sx[i] = 0; sy[i] = 0; sen[i] = 0; snum[i] = 0; end
    start_build(45, 1);
    chk("after_reset_len", e_len, 9);
    finish_build("after_reset", 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
